// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared definitions for the shift execute stage: shift
//                operation encodings and default datapath widths.
//  Revision    : 1.0  initial release
// ============================================================================
package shift_pkg;

  // Default datapath geometry. SH_SHW must satisfy 2**SH_SHW > SH_WIDTH so
  // that every amount up to and beyond the operand width can be expressed.
  localparam int SH_WIDTH = 16;
  localparam int SH_SHW   = 5;

  // Shift operation encoding carried on in_op.
  typedef enum logic [1:0] {
    SH_SLL = 2'b00,   // logical left
    SH_SRL = 2'b01,   // logical right
    SH_SRA = 2'b10,   // arithmetic right (sign fill)
    SH_ROL = 2'b11    // rotate left by amount mod width
  } shift_op_t;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_exec_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : shift_exec_stage_if
//  Description : Bundles the upstream (op issue) and downstream (writeback)
//                valid/ready handshakes of the shift execute stage.
//  Revision    : 1.0  initial release
//
//  Signals
//    in_valid    upstream op is valid
//    in_ready    stage can accept an op this cycle
//    in_op       2-bit operation (see shift_pkg::shift_op_t)
//    in_data     WIDTH-bit operand
//    in_shamt    SHW-bit unsigned shift amount
//    out_valid   result is valid
//    out_ready   writeback accepts the result
//    out_result  WIDTH-bit shifted value
//    out_carry   last bit shifted out
//    out_zero    out_result == 0
//
//  Modports
//    slave   : the execute stage itself
//    master  : the environment (issue logic + writeback)
// ============================================================================
interface shift_exec_stage_if
  import shift_pkg::*;
#(
  parameter int WIDTH = SH_WIDTH,
  parameter int SHW   = SH_SHW
);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_zero;

  modport slave (
    input  in_valid,
    input  in_op,
    input  in_data,
    input  in_shamt,
    output in_ready,
    output out_valid,
    output out_result,
    output out_carry,
    output out_zero,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_op,
    output in_data,
    output in_shamt,
    input  in_ready,
    input  out_valid,
    input  out_result,
    input  out_carry,
    input  out_zero,
    output out_ready
  );

endinterface : shift_exec_stage_if
`default_nettype wire

// File: rtl/shift_core.sv
`default_nettype none
// ============================================================================
//  Module      : shift_core
//  Description : Purely combinational shifter. Computes result and carry for
//                SLL / SRL / SRA / ROL using a single left-shift network.
//                Right shifts bit-reverse the operand on the way in and the
//                result on the way out.
//  Revision    : 1.0  initial release
//
//  Ports
//    op_i      in   2      operation (shift_pkg::shift_op_t encoding)
//    data_i    in   WIDTH  operand
//    shamt_i   in   SHW    shift amount, unsigned
//    result_o  out  WIDTH  shifted value
//    carry_o   out  1      last bit shifted out (0 for ROL)
// ============================================================================
module shift_core
  import shift_pkg::*;
#(
  parameter int WIDTH = SH_WIDTH,
  parameter int SHW   = SH_SHW
)
(
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   shamt_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
);

  // The network is twice the operand width. The upper half catches the bits
  // pushed out of the operand: bit WIDTH is always the last bit shifted out,
  // and for a rotate the upper half holds the wrapped-around bits.
  localparam int EXT = 2 * WIDTH;

  logic [WIDTH-1:0] w_data_rev;
  logic [WIDTH-1:0] w_low_rev;
  logic [WIDTH-1:0] w_net_in;
  logic [SHW-1:0]   w_rot_amt;
  logic [SHW-1:0]   w_amt;
  logic             w_is_right;
  logic             w_sra_fill;
  logic [EXT-1:0]   w_fill_mask;
  logic [EXT-1:0]   w_shifted;

  // Bit reversal of the operand (input side) and of the low half of the
  // network output (output side) for right shifts.
  for (genvar i = 0; i < WIDTH; i++) begin : g_rev_in
    assign w_data_rev[i] = data_i[WIDTH-1-i];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_rev_out
    assign w_low_rev[i] = w_shifted[WIDTH-1-i];
  end

  // Rotation only needs the amount modulo the width.
  assign w_rot_amt = SHW'(32'(shamt_i) % 32'(WIDTH));

  always_comb begin
    w_is_right  = 1'b0;
    w_sra_fill  = 1'b0;
    w_net_in    = data_i;
    w_amt       = shamt_i;
    w_fill_mask = '0;
    w_shifted   = '0;
    result_o    = '0;
    carry_o     = 1'b0;

    case (shift_op_t'(op_i))
      SH_SRL: w_is_right = 1'b1;
      SH_SRA: begin
        w_is_right = 1'b1;
        w_sra_fill = data_i[WIDTH-1];
      end
      SH_ROL:  w_amt = w_rot_amt;
      default: ;
    endcase

    if (w_is_right) begin
      w_net_in = w_data_rev;
    end

    // Arithmetic fill: in the reversed domain the sign bits enter from the
    // bottom, so every position below the amount is forced to the sign. The
    // mask spans the full network, which also makes bit WIDTH equal to the
    // sign once the amount exceeds the width.
    if (w_sra_fill) begin
      w_fill_mask = ~({EXT{1'b1}} << w_amt);
    end

    w_shifted = ({{WIDTH{1'b0}}, w_net_in} << w_amt) | w_fill_mask;

    case (shift_op_t'(op_i))
      SH_SLL: begin
        result_o = w_shifted[WIDTH-1:0];
        carry_o  = w_shifted[WIDTH];
      end
      SH_SRL, SH_SRA: begin
        result_o = w_low_rev;
        carry_o  = w_shifted[WIDTH];
      end
      default: begin
        // Rotate: recombine the bits that left the top with the rest.
        result_o = w_shifted[WIDTH-1:0] | w_shifted[EXT-1:WIDTH];
        carry_o  = 1'b0;
      end
    endcase
  end

endmodule : shift_core
`default_nettype wire

// File: rtl/shift_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module      : shift_exec_stage
//  Description : Two-stage pipelined shift execute stage. S1 registers the
//                op/operand/amount, S2 registers result and flags for
//                writeback. Full throughput of one op per clock with
//                back-pressure from writeback propagating upstream.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk    in   1   single clock, rising edge
//    rst_n  in   1   asynchronous active-low reset
//    bus    slave modport of shift_exec_stage_if:
//             in_valid/in_ready/in_op/in_data/in_shamt   (upstream)
//             out_valid/out_ready/out_result/out_carry/out_zero (writeback)
// ============================================================================
module shift_exec_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = SH_WIDTH,
  parameter int SHW   = SH_SHW
)
(
  input  logic              clk,
  input  logic              rst_n,
  shift_exec_stage_if.slave bus
);

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic             s1_valid_q,   s1_valid_d;
  logic [1:0]       s1_op_q,      s1_op_d;
  logic [WIDTH-1:0] s1_data_q,    s1_data_d;
  logic [SHW-1:0]   s1_shamt_q,   s1_shamt_d;

  logic             out_valid_q,  out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic             out_carry_q,  out_carry_d;
  logic             out_zero_q,   out_zero_d;

  logic             w_s2_adv;
  logic             w_can_accept;
  logic [WIDTH-1:0] w_core_result;
  logic             w_core_carry;

  // S2 can take a new value when empty or when its content leaves this cycle;
  // S1 can take a new op when empty or when it moves into S2 this cycle.
  assign w_s2_adv     = !out_valid_q || bus.out_ready;
  assign w_can_accept = !s1_valid_q || w_s2_adv;

  // in_ready is forced low while reset is held; the registers themselves
  // ignore their next-state inputs during reset, so the gating stays off the
  // internal paths.
  assign bus.in_ready   = rst_n && w_can_accept;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_carry  = out_carry_q;
  assign bus.out_zero   = out_zero_q;

  // ---------------------------------------------------------------------------
  // Shift datapath, fed from S1
  // ---------------------------------------------------------------------------
  shift_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .op_i     (s1_op_q),
    .data_i   (s1_data_q),
    .shamt_i  (s1_shamt_q),
    .result_o (w_core_result),
    .carry_o  (w_core_carry)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_op_d      = s1_op_q;
    s1_data_d    = s1_data_q;
    s1_shamt_d   = s1_shamt_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_carry_d  = out_carry_q;
    out_zero_d   = out_zero_q;

    // S1: when it may move, it becomes whatever upstream offers. Operand
    // registers only load on a real transfer to avoid needless toggling.
    if (w_can_accept) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_op_d    = bus.in_op;
        s1_data_d  = bus.in_data;
        s1_shamt_d = bus.in_shamt;
      end
    end

    // S2: while stalled (out_valid && !out_ready) everything holds.
    if (w_s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_result_d = w_core_result;
        out_carry_d  = w_core_carry;
        out_zero_d   = (w_core_result == '0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= '0;
      s1_data_q    <= '0;
      s1_shamt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_carry_q  <= 1'b0;
      out_zero_q   <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_data_q    <= s1_data_d;
      s1_shamt_q   <= s1_shamt_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_carry_q  <= out_carry_d;
      out_zero_q   <= out_zero_d;
    end
  end

endmodule : shift_exec_stage
`default_nettype wire

// File: tb/tb_shift_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_exec_stage
//  Description : Self-checking bench for shift_exec_stage. Expected results
//                are queued when an op is accepted and compared when the
//                stage hands a result to writeback.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_exec_stage;
  import shift_pkg::*;

  localparam int W = SH_WIDTH;
  localparam int S = SH_SHW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_exec_stage_if #(.WIDTH(W), .SHW(S)) bus ();

  shift_exec_stage #(.WIDTH(W), .SHW(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] res, input logic c, input logic z);
    exp_t e;
    e.res = res;
    e.c   = c;
    e.z   = z;
    return e;
  endfunction

  // Reference model written straight from the operation definitions.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] d, input int unsigned k);
    exp_t e;
    e = '0;
    case (op)
      2'b00: begin
        if (k < W) e.res = d << k;
        if (k >= 1 && k <= W) e.c = d[W-k];
      end
      2'b01: begin
        if (k < W) e.res = d >> k;
        if (k >= 1 && k <= W) e.c = d[k-1];
      end
      2'b10: begin
        e.res = (k < W) ? W'($signed(d) >>> k) : {W{d[W-1]}};
        if (k >= 1 && k <= W) e.c = d[k-1];
        else if (k > W)       e.c = d[W-1];
      end
      default: begin
        for (int i = 0; i < W; i++) e.res[(i + k) % W] = d[i];
      end
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Output monitor: pops the scoreboard on every writeback transfer and
  // verifies outputs stay frozen while writeback stalls.
  logic [W-1:0] held_res;
  logic         held_c;
  logic         held_z;
  logic         held_v = 1'b0;
  int           n_out  = 0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && bus.out_valid) begin
      if (held_v)
        check("stall_hold", {bus.out_result, bus.out_carry, bus.out_zero},
              {held_res, held_c, held_z});
      if (bus.out_ready) begin
        held_v = 1'b0;
        if (sb.size() == 0) begin
          check("unexpected_out_valid", bus.out_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          check("result", bus.out_result, e.res);
          check("carry",  bus.out_carry,  e.c);
          check("zero",   bus.out_zero,   e.z);
          n_out++;
        end
      end else begin
        held_v   = 1'b1;
        held_res = bus.out_result;
        held_c   = bus.out_carry;
        held_z   = bus.out_zero;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  // Present one op, wait (bounded) for acceptance, queue its expectation.
  // Called and returns at posedge+1. If the op is blocked, writeback is
  // released so the pipeline can drain.
  task automatic send(input logic [1:0] op, input logic [W-1:0] d, input logic [S-1:0] k, input exp_t e);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_data  = d;
    bus.in_shamt = k;
    @(negedge clk);
    while (!bus.in_ready && t < 40) begin
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) check("accept_timeout", bus.in_ready, 1'b1);
    else               sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    bus.out_ready = 1'b1;
    while ((sb.size() != 0 || bus.out_valid) && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_left", sb.size(), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_t a, b, c;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.out_ready = 1'b1;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid",  bus.out_valid,  1'b0);
    check("rst_in_ready",   bus.in_ready,   1'b0);
    check("rst_out_result", bus.out_result, '0);
    check("rst_out_carry",  bus.out_carry,  1'b0);
    check("rst_out_zero",   bus.out_zero,   1'b0);
    rst_n = 1'b1;
    #1 check("rel_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;

    // ---- SLL basic + latency ----
    send(SH_SLL, 16'hAAAA, 5'd1, mk(16'h5554, 1'b1, 1'b0));
    check("lat_accept_edge", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    check("lat_next_edge", bus.out_valid, 1'b1);
    drain();

    // ---- SRA / SLL boundary amounts, ROL, SRL k=0 (back to back) ----
    send(SH_SRA, 16'h8000, 5'd15, mk(16'hFFFF, 1'b0, 1'b0));
    send(SH_SRA, 16'h8000, 5'd20, mk(16'hFFFF, 1'b1, 1'b0));
    send(SH_SLL, 16'h00FF, 5'd16, mk(16'h0000, 1'b1, 1'b1));
    send(SH_SLL, 16'h00FF, 5'd17, mk(16'h0000, 1'b0, 1'b1));
    send(SH_ROL, 16'hF000, 5'd4,  mk(16'h000F, 1'b0, 1'b0));
    send(SH_ROL, 16'hF000, 5'd20, mk(16'h000F, 1'b0, 1'b0));
    send(SH_SRL, 16'h0001, 5'd0,  mk(16'h0001, 1'b0, 1'b0));
    send(SH_SRL, 16'h8001, 5'd16, mk(16'h0000, 1'b1, 1'b1));
    send(SH_SRA, 16'h7FFF, 5'd31, mk(16'h0000, 1'b0, 1'b1));
    drain();

    // ---- reset with two ops in flight ----
    bus.out_ready = 1'b0;
    send(SH_SLL, 16'h1234, 5'd4, model(SH_SLL, 16'h1234, 4));
    send(SH_SRL, 16'h1234, 5'd4, model(SH_SRL, 16'h1234, 4));
    check("inflight_valid", bus.out_valid, 1'b1);
    rst_n = 1'b0;
    sb.delete();
    #1 check("async_rst_valid", bus.out_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold_valid", bus.out_valid, 1'b0);
      check("rst_hold_ready", bus.in_ready,  1'b0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    #1 check("rel2_in_ready", bus.in_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale_out", bus.out_valid, 1'b0);
    end
    @(posedge clk); #1;

    // ---- stall: A,B,C with writeback blocked for 4 clocks ----
    a = model(SH_SLL, 16'h0F0F, 3);
    b = model(SH_SRA, 16'hF00D, 2);
    c = model(SH_ROL, 16'h8421, 5);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_op = SH_SLL; bus.in_data = 16'h0F0F; bus.in_shamt = 5'd3;
    @(negedge clk);
    check("t6_ready_A", bus.in_ready, 1'b1);
    sb.push_back(a);
    @(posedge clk); #1;
    bus.in_op = SH_SRA; bus.in_data = 16'hF00D; bus.in_shamt = 5'd2;
    @(negedge clk);
    check("t6_ready_B", bus.in_ready, 1'b1);
    sb.push_back(b);
    @(posedge clk); #1;
    bus.in_op = SH_ROL; bus.in_data = 16'h8421; bus.in_shamt = 5'd5;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t6_stall_ready", bus.in_ready,   1'b0);
      check("t6_stall_valid", bus.out_valid,  1'b1);
      check("t6_hold_A",      bus.out_result, a.res);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t6_ready_C", bus.in_ready, 1'b1);
    sb.push_back(c);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("t6_emit_B_valid", bus.out_valid, 1'b1);
    @(posedge clk); #1;
    check("t6_emit_C_valid", bus.out_valid, 1'b1);
    @(posedge clk); #1;
    check("t6_done_valid", bus.out_valid, 1'b0);
    check("t6_all_emitted", sb.size(), 0);

    // ---- random stream with random writeback back-pressure ----
    for (int i = 0; i < 40; i++) begin
      logic [1:0]   op;
      logic [W-1:0] d;
      logic [S-1:0] k;
      op = 2'($urandom_range(0, 3));
      d  = W'($urandom);
      k  = S'($urandom_range(0, 31));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      send(op, d, k, model(op, d, k));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_shift_exec_stage
`default_nettype wire
